// File: rtl/wb_byte_splitter.sv
// wb_byte_splitter
//   Breaks any 32-bit Wishbone master access into a sequence of single-lane
//   slave accesses, one per enabled byte lane. The highest lane goes first.
//   Read data from the lanes is gathered into one word. The master gets a
//   single termination after the last lane.
//
//   Optional feature: define WB_BYTE_SPLITTER_HALF_EN to merge a fully
//   enabled upper or lower half-word into a single 16-bit slave access.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wbm_*_i / wbm_*_o      master side (32-bit data, 4 byte selects)
//   wbs_*_o / wbs_*_i      slave side (one lane or half-word per access)
//   wbm_cti_i, wbm_bte_i   ignored; wbs_cti_o/wbs_bte_o tied to classic
module wb_byte_splitter #(
  parameter int unsigned AW = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wbm_adr_i,
  input  logic [31:0]   wbm_dat_i,
  input  logic [3:0]    wbm_sel_i,
  input  logic          wbm_we_i,
  input  logic          wbm_cyc_i,
  input  logic          wbm_stb_i,
  input  logic [2:0]    wbm_cti_i,
  input  logic [1:0]    wbm_bte_i,
  output logic [31:0]   wbm_dat_o,
  output logic          wbm_ack_o,
  output logic          wbm_err_o,
  output logic          wbm_rty_o,
  output logic [AW-1:0] wbs_adr_o,
  output logic [31:0]   wbs_dat_o,
  output logic [3:0]    wbs_sel_o,
  output logic          wbs_we_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic [2:0]    wbs_cti_o,
  output logic [1:0]    wbs_bte_o,
  input  logic [31:0]   wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_err_i,
  input  logic          wbs_rty_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-3:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic [3:0]    rem_q, rem_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    sel_q, sel_d;
  logic [1:0]    off_q, off_d;
  logic          cyc_q, cyc_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          rty_q, rty_d;
  logic [3:0]    rem_left;

  logic unused_ok;
  assign unused_ok = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0]};

  // Select pattern of the next slave access, taken from the lanes still pending.
  function automatic logic [3:0] next_sel(input logic [3:0] rem);
    logic [3:0] s;
    s = 4'b0000;
`ifdef WB_BYTE_SPLITTER_HALF_EN
    if (rem[3:2] == 2'b11) begin
      s = 4'b1100;
    end else if (rem[3:2] == 2'b00 && rem[1:0] == 2'b11) begin
      s = 4'b0011;
    end else
`endif
    if (rem[3])      s = 4'b1000;
    else if (rem[2]) s = 4'b0100;
    else if (rem[1]) s = 4'b0010;
    else if (rem[0]) s = 4'b0001;
    return s;
  endfunction

  // Big-endian byte offset of the most significant lane in a select pattern.
  function automatic logic [1:0] sel_off(input logic [3:0] s);
    logic [1:0] o;
    if (s[3])      o = 2'd0;
    else if (s[2]) o = 2'd1;
    else if (s[1]) o = 2'd2;
    else           o = 2'd3;
    return o;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    rem_d    = rem_q;
    rdata_d  = rdata_q;
    sel_d    = sel_q;
    off_d    = off_q;
    cyc_d    = cyc_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rty_d    = 1'b0;
    rem_left = rem_q & ~sel_q;
    case (state_q)
      S_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          adr_d   = wbm_adr_i[AW-1:2];
          dat_d   = wbm_dat_i;
          we_d    = wbm_we_i;
          rem_d   = wbm_sel_i;
          rdata_d = 32'h0;
          if (wbm_sel_i == 4'b0000) begin
            ack_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            sel_d   = next_sel(wbm_sel_i);
            off_d   = sel_off(next_sel(wbm_sel_i));
            cyc_d   = 1'b1;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // Master abort wins over any slave termination in the same cycle.
        if (!wbm_cyc_i) begin
          cyc_d   = 1'b0;
          state_d = S_IDLE;
        end else if (wbs_err_i) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (wbs_rty_i) begin
          cyc_d   = 1'b0;
          rty_d   = 1'b1;
          state_d = S_DONE;
        end else if (wbs_ack_i) begin
          rdata_d = (rdata_q & ~lane_mask(sel_q)) | (wbs_dat_i & lane_mask(sel_q));
          rem_d   = rem_left;
          if (rem_left != 4'b0000) begin
            sel_d = next_sel(rem_left);
            off_d = sel_off(next_sel(rem_left));
          end else begin
            cyc_d   = 1'b0;
            ack_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      dat_q   <= 32'h0;
      we_q    <= 1'b0;
      rem_q   <= 4'b0000;
      rdata_q <= 32'h0;
      sel_q   <= 4'b0000;
      off_q   <= 2'd0;
      cyc_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      rem_q   <= rem_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
    end
  end

  assign wbm_dat_o = rdata_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbm_rty_o = rty_q;
  assign wbs_adr_o = {adr_q, off_q};
  assign wbs_dat_o = dat_q;
  assign wbs_sel_o = sel_q;
  assign wbs_we_o  = we_q;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_byte_splitter.sv
// Testbench for wb_byte_splitter: directed cases plus randomized traffic.
// The expected slave access list and master response are computed from the
// lane-splitting rules and a byte-addressed reference memory, then compared
// by a slave-side checker and a master-side termination monitor.
module tb_wb_byte_splitter;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } acc_t;

  typedef struct {
    int          term;   // 0 ack, 1 err, 2 rty
    logic [31:0] dat;
    bit          chk_dat;
  } exp_t;

  logic        clk;
  logic        wb_rst_i;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic [3:0]  wbm_sel_i;
  logic        wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [2:0]  wbm_cti_i;
  logic [1:0]  wbm_bte_i;
  logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic        wbs_ack_i, wbs_err_i, wbs_rty_i;

  int   n_vec = 0;
  int   n_bad = 0;
  acc_t acc_q[$];
  exp_t sb_q[$];
  logic [7:0] ref_mem [64];
  logic [7:0] slv_mem [64];
  int   txn_id = 0;
  int   f_idx = -1;
  int   f_kind = 0;
  bit   waits_en = 0;
  bit   chk_acc = 1;

  wb_byte_splitter #(.AW(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Access plan: one entry per slave access, highest lane first.
  task automatic build_plan(input logic [3:0] sel, output logic [3:0] plan[$]);
    logic [3:0] s;
    plan.delete();
`ifdef WB_BYTE_SPLITTER_HALF_EN
    if (sel[3:2] == 2'b11) plan.push_back(4'b1100);
    else for (int k = 3; k >= 2; k--) if (sel[k]) begin s = 4'b0; s[k] = 1'b1; plan.push_back(s); end
    if (sel[1:0] == 2'b11) plan.push_back(4'b0011);
    else for (int k = 1; k >= 0; k--) if (sel[k]) begin s = 4'b0; s[k] = 1'b1; plan.push_back(s); end
`else
    for (int k = 3; k >= 0; k--) if (sel[k]) begin s = 4'b0; s[k] = 1'b1; plan.push_back(s); end
`endif
  endtask

  function automatic logic [1:0] first_off(input logic [3:0] s);
    for (int k = 3; k >= 0; k--) if (s[k]) return 2'(3 - k);
    return 2'd0;
  endfunction

  task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input int fidx, input int fkind, input bit chk_lat);
    logic [3:0] plan[$];
    int   n_iss, base, cnt;
    bit   faulted, done;
    acc_t a;
    exp_t e;
    build_plan(sel, plan);
    faulted = (fidx >= 0) && (fidx < plan.size());
    n_iss   = faulted ? fidx + 1 : plan.size();
    base    = int'(adr[5:2]) * 4;
    e.dat   = 32'h0;
    for (int i = 0; i < n_iss; i++) begin
      a.adr = {adr[31:2], first_off(plan[i])};
      a.sel = plan[i];
      a.we  = we;
      a.dat = dat;
      acc_q.push_back(a);
      if (!(faulted && i == n_iss - 1)) begin
        for (int k = 0; k < 4; k++) if (plan[i][k]) begin
          if (we) ref_mem[base + 3 - k] = dat[8*k +: 8];
          else    e.dat[8*k +: 8] = ref_mem[base + 3 - k];
        end
      end
    end
    e.term    = !faulted ? 0 : ((fkind == 0 || fkind == 2) ? 1 : 2);
    e.chk_dat = !we;
    sb_q.push_back(e);
    f_idx  = faulted ? fidx : -1;
    f_kind = fkind;
    txn_id++;
    @(negedge clk);
    wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = sel; wbm_we_i = we;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    @(posedge clk);
    cnt  = 0;
    done = 0;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) done = 1;
    end
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL txn_timeout: no termination after %0d cycles, expected one", cnt);
      sb_q.delete(); acc_q.delete();
    end else if (chk_lat) begin
      chk("term_latency", cnt, n_iss + 1);
    end
  endtask

  // Master-side monitor: every termination pops one expected response.
  initial begin : monitor
    exp_t e;
    int   got;
    forever begin
      @(negedge clk);
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
        n_vec++;
        got = wbm_ack_o ? 0 : (wbm_err_o ? 1 : 2);
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_term: got ack/err/rty=%b%b%b expected none", wbm_ack_o, wbm_err_o, wbm_rty_o);
        end else begin
          e = sb_q.pop_front();
          if ((32'(wbm_ack_o) + 32'(wbm_err_o) + 32'(wbm_rty_o)) != 1 || got != e.term) begin
            n_bad++;
            $display("FAIL term_kind: got ack/err/rty=%b%b%b expected kind %0d", wbm_ack_o, wbm_err_o, wbm_rty_o, e.term);
          end else if (e.chk_dat && wbm_dat_o !== e.dat) begin
            n_bad++;
            $display("FAIL read_data: got %h expected %h", wbm_dat_o, e.dat);
          end
        end
      end
    end
  end

  // Slave model with byte memory, optional wait states and fault injection.
  initial begin : slave
    int   in_acc, wcnt, acc_idx, last_txn, base;
    logic [3:0]  a_sel;
    logic [31:0] a_adr;
    acc_t a;
    in_acc = 0; wcnt = 0; acc_idx = 0; last_txn = -1;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0; wbs_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
      wbs_dat_i = $urandom;
      if (txn_id != last_txn) begin last_txn = txn_id; acc_idx = 0; end
      if (wbs_cyc_o && wbs_stb_o) begin
        if (in_acc == 0) begin
          in_acc = 1;
          wcnt   = waits_en ? $urandom_range(0, 2) : 0;
          a_sel  = wbs_sel_o;
          a_adr  = wbs_adr_o;
          if (chk_acc) begin
            n_vec++;
            if (acc_q.size() == 0) begin
              n_bad++;
              $display("FAIL slave_access: got strobe sel %b adr %h expected none", wbs_sel_o, wbs_adr_o);
            end else begin
              a = acc_q.pop_front();
              if (wbs_adr_o !== a.adr || wbs_sel_o !== a.sel || wbs_we_o !== a.we ||
                  (a.we && wbs_dat_o !== a.dat)) begin
                n_bad++;
                $display("FAIL slave_access: got adr %h sel %b we %b dat %h expected adr %h sel %b we %b dat %h",
                         wbs_adr_o, wbs_sel_o, wbs_we_o, wbs_dat_o, a.adr, a.sel, a.we, a.dat);
              end
            end
          end
        end else begin
          chk("slave_hold_adr", wbs_adr_o, a_adr);
          chk("slave_hold_sel", {28'h0, wbs_sel_o}, {28'h0, a_sel});
        end
        if (wcnt > 0) begin
          wcnt--;
        end else begin
          base = int'(wbs_adr_o[5:2]) * 4;
          if (acc_idx == f_idx) begin
            case (f_kind)
              0: wbs_err_i = 1'b1;
              1: wbs_rty_i = 1'b1;
              2: begin wbs_err_i = 1'b1; wbs_rty_i = 1'b1; wbs_ack_i = 1'b1; end
              default: begin wbs_rty_i = 1'b1; wbs_ack_i = 1'b1; end
            endcase
          end else begin
            wbs_ack_i = 1'b1;
            for (int k = 0; k < 4; k++) if (wbs_sel_o[k]) begin
              if (wbs_we_o) slv_mem[base + 3 - k] = wbs_dat_o[8*k +: 8];
              else          wbs_dat_i[8*k +: 8] = slv_mem[base + 3 - k];
            end
          end
          acc_idx++;
          in_acc = 0;
        end
      end else begin
        in_acc = 0;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wbm_ack"}, {31'h0, wbm_ack_o}, 32'h0);
    chk({tag, "_wbm_err"}, {31'h0, wbm_err_o}, 32'h0);
    chk({tag, "_wbm_rty"}, {31'h0, wbm_rty_o}, 32'h0);
    chk({tag, "_wbm_dat"}, wbm_dat_o, 32'h0);
    chk({tag, "_wbs_cyc_stb"}, {30'h0, wbs_cyc_o, wbs_stb_o}, 32'h0);
    chk({tag, "_wbs_sel"}, {28'h0, wbs_sel_o}, 32'h0);
    chk({tag, "_wbs_adr"}, wbs_adr_o, 32'h0);
    chk({tag, "_wbs_dat_we"}, wbs_dat_o | {31'h0, wbs_we_o}, 32'h0);
    chk({tag, "_wbs_cti_bte"}, {27'h0, wbs_cti_o, wbs_bte_o}, 32'h0);
  endtask

  initial begin : driver
    logic [7:0] v;
    wb_rst_i = 1'b1;
    wbm_adr_i = 32'h0; wbm_dat_i = 32'h0; wbm_sel_i = 4'h0; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_cti_i = 3'h0; wbm_bte_i = 2'h0;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      slv_mem[i] = v;
    end
    ref_mem[20] = 8'hAA; ref_mem[21] = 8'hBB; ref_mem[22] = 8'hCC; ref_mem[23] = 8'hDD;
    slv_mem[20] = 8'hAA; slv_mem[21] = 8'hBB; slv_mem[22] = 8'hCC; slv_mem[23] = 8'hDD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    wb_rst_i = 1'b0;

    // Word read of AA BB CC DD, then hold of the gathered word.
    run_txn(32'h0000_0014, 32'h0, 4'b1111, 1'b0, -1, 0, 1);
    chk("word_read_dat", wbm_dat_o, 32'hAABBCCDD);
    // Two-lane write.
    run_txn(32'h0000_0018, 32'h11223344, 4'b0101, 1'b1, -1, 0, 1);
    // Error on the first lane of a two-lane read.
    run_txn(32'h0000_001C, 32'h0, 4'b1100, 1'b0, 0, 0, 1);
    // Empty select: no slave traffic, immediate ack.
    run_txn(32'h0000_0020, 32'h0, 4'b0000, 1'b0, -1, 0, 1);
    // Three lanes with err+rty+ack and rty+ack on the middle access.
    run_txn(32'h0000_0024, 32'h0, 4'b0111, 1'b0, 1, 2, 1);
    run_txn(32'h0000_0028, 32'h0, 4'b1011, 1'b0, 1, 3, 1);

    // Reset during the second lane of a 4-lane read.
    chk_acc = 1'b0; f_idx = -1; txn_id++;
    @(negedge clk);
    wbm_adr_i = 32'h0000_0030; wbm_sel_i = 4'b1111; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    wb_rst_i = 1'b1; wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    wb_rst_i = 1'b0;
    @(negedge clk);
    acc_q.delete(); chk_acc = 1'b1;
    run_txn(32'h0000_0034, 32'h0, 4'b1111, 1'b0, -1, 0, 1);

    // Master abort during the second lane.
    chk_acc = 1'b0; f_idx = -1; txn_id++;
    @(negedge clk);
    wbm_adr_i = 32'h0000_0038; wbm_sel_i = 4'b1111; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(negedge clk);
    chk("abort_stb", {30'h0, wbs_cyc_o, wbs_stb_o}, 32'h0);
    repeat (3) @(negedge clk);
    acc_q.delete(); chk_acc = 1'b1;

    // Randomized traffic with wait states and occasional faults.
    waits_en = 1'b1;
    for (int t = 0; t < 200; t++) begin
      int fi;
      fi = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn($urandom, $urandom, 4'($urandom), 1'($urandom), fi, int'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("acc_drained", acc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_byte_splitter.md
# wb_byte_splitter

Wishbone access sequencer placed directly upstream of the 8/16-bit data resizer on narrow-slave ports. It accepts any 32-bit master access, whatever its select pattern, and issues one single-lane slave access per enabled byte lane. Read data is gathered into a full word and the master is acknowledged once, after the last lane. The downstream resizer therefore only ever sees the one-hot select patterns it supports, and its unaligned-access error never fires for legal multi-byte CPU accesses.

## Interface
- aw, 32, address width
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbm_adr_i  in  aw  master address
- wbm_dat_i  in  32  master write data
- wbm_sel_i  in  4  byte lane enables; bit 3 = [31:24]
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  1 each  master control
- wbm_cti_i  in  3  ignored
- wbm_bte_i  in  2  ignored
- wbm_dat_o  out  32  gathered read data, registered
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  1 each  one-cycle registered terminations
- wbs_adr_o  out  aw  {latched adr[aw-1:2], lane offset}
- wbs_dat_o  out  32  latched write word, unmodified
- wbs_sel_o  out  4  one-hot lane, or a half-word pair under the config macro
- wbs_we_o, wbs_cyc_o, wbs_stb_o  out  1 each  registered slave control
- wbs_cti_o  out  3  constant 3'b000 (classic)
- wbs_bte_o  out  2  constant 2'b00
- wbs_dat_i  in  32  slave read data
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  slave terminations

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE, on wbm_cyc_i & wbm_stb_i:**
  - Latch adr, dat, we and sel; remaining = sel; clear rdata.
  - If sel == 0, go straight to DONE with ack, with no slave access.
  - Otherwise, go to ACCESS with the first lane driven.
- **Lane order:** highest set bit of remaining first.
- **Lane to address offset (big-endian):** lane 3 → 0, lane 2 → 1, lane 1 → 2, lane 0 → 3.
- **ACCESS, on wbs_ack_i:**
  - Capture wbs_dat_i into rdata for that lane only.
  - Clear the lane in remaining.
  - If bits remain, drive the next lane's adr/sel from the next cycle, keeping cyc/stb high.
  - If none remain, drop cyc/stb and go to DONE with ack.
- **ACCESS, on wbs_err_i or wbs_rty_i:**
  - Drop cyc/stb; go to DONE with err or rty.
  - Remaining lanes are not issued.
  - Priority when asserted together: err > rty > ack.
- **ACCESS, master drops wbm_cyc_i:** abort. Drop slave cyc/stb at the next edge, go to IDLE, and issue no master termination.
- **DONE:** pulse exactly one of ack/err/rty for one cycle, with wbm_dat_o = rdata; then go to IDLE.
- Lanes not accessed read as zero; wbm_dat_o holds its value until the next accept.
- Writes: wbs_dat_o carries the whole latched word; wbs_we_o is the latched we.

## Timing
- **Reset:** every output is 0 (wbs_cti_o/wbs_bte_o are constant 0); state = IDLE; remaining = 0; rdata = 0.
- **Reset mid-operation:** slave cyc/stb are low from the next cycle, and no master termination is produced.
- **Request sampled at edge E0, with a zero-wait slave:**
  - wbs_stb_o is high in cycles 1..N, where N = number of accesses.
  - wbm_ack_o is high in cycle N+1.
  - sel == 0: ack in cycle 1.
- **Slave wait states:** each one extends the sequence by one cycle.
- **Back-to-back:** a new request may be accepted in the IDLE cycle that follows DONE; minimum turnaround is one cycle.
- **Output stability:** slave outputs are registered; adr/sel change only at an edge where wbs_ack_i was sampled high.

## Configuration
- **Macro: WB_BYTE_SPLITTER_HALF_EN.**
- **Defined:**
  - If remaining[3:2] == 2'b11, issue one access with sel 4'b1100 at offset 0.
  - Else if remaining[1:0] == 2'b11 and the upper half is done, issue sel 4'b0011 at offset 2.
  - Result: sel 4'b1111 takes 2 accesses; sel 4'b0111 takes 2 accesses (byte lane 2, then half 0011).
  - The rdata capture writes both lanes of a half-word access.
- **Undefined:** every access is a single byte lane; sel 4'b1111 takes 4 accesses.

## Test plan
- **Word read, sel=1111, macro off, slave returns 0xAA, 0xBB, 0xCC, 0xDD at offsets 0..3:**
  - Four slave strobes with sel 1000, 0100, 0010, 0001 at adr offsets 0, 1, 2, 3.
  - wbm_dat_o = 0xAABBCCDD.
  - ack in cycle 5.
- **Write, sel=0101, dat=0x11223344:**
  - Two writes: sel 0100 at offset 1, then sel 0001 at offset 3.
  - wbs_dat_o = 0x11223344 throughout.
  - One master ack.
- **Read, sel=1100, err on the first slave access:**
  - wbm_err_o pulses once.
  - No second strobe.
  - wbm_ack_o is never high.
- **sel=0000:**
  - wbs_cyc_o stays 0.
  - wbm_ack_o is high in cycle 1.
- **wb_rst_i asserted during the second lane of a 4-lane read:**
  - All outputs 0 on the next cycle.
  - No master termination.
  - A following request completes normally.
- **Macro on, read sel=1111, slave returns 0xAABB then 0xCCDD:**
  - Two accesses: sel 1100 at offset 0, then sel 0011 at offset 2.
  - wbm_dat_o = 0xAABBCCDD.
  - ack in cycle 3.
